timeslot_arbiter: RTL and testbench
===================================

# timeslot_arbiter

Round-robin time-slot arbiter that shares one counted resource among R requesters, granting each requester exclusive ownership for at most a programmable number of clock cycles. An internal N-bit down-counter meters each slot. The arbiter sits between the requesting agents and the shared counter/datapath, and exposes the current owner and remaining slot length for monitoring.

## Interface
- R, 4, number of requesters (2..16)
- N, 8, width of slot quantum and remaining-cycle counter
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  R  per-requester request level; held high while the requester wants the resource
- rel  input  R  per-requester early release; only the owner's bit is honoured, all others are ignored
- quantum  input  N  slot length in cycles, sampled on grant entry; 0 is treated as 1
- grant  output  R  one-hot grant; all zero when no requester owns the resource
- busy  output  1  high while in GRANT
- owner  output  $clog2(R)  index of the current or most recent owner
- remaining  output  N  cycles left in the current slot, including the present cycle
- expire  output  1  one-cycle pulse when a slot ends by timeout

## Operation
- Three-state FSM: IDLE, GRANT, GAP. Internal round-robin pointer ptr.
- IDLE: if req != 0, select the first set bit of req scanning ptr, ptr+1, ..., wrapping mod R. Next state GRANT; owner <= selected index; remaining <= (quantum==0 ? 1 : quantum). If req == 0, stay in IDLE.
- GRANT: grant = one-hot(owner), busy = 1. The slot ends in this cycle if any of the following holds:
  - (a) rel[owner] = 1
  - (b) req[owner] = 0
  - (c) remaining == 1
- GRANT, slot ends: next state GAP; ptr <= (owner+1) mod R; remaining <= 0.
  - expire <= 1 for the following cycle only when (c) holds and neither (a) nor (b) holds.
- GRANT, slot continues: remaining <= remaining - 1.
- GAP: one dead cycle; grant = 0, busy = 0. Next state is unconditionally IDLE. This guarantees at least two grant-free cycles between owners (GAP plus the IDLE arbitration cycle).
- Requests from non-owners during GRANT or GAP are not latched. They are seen only by level in IDLE.
- Changes to quantum during GRANT have no effect on the current slot.
- Arithmetic: remaining never underflows; it is only decremented when > 1. ptr wraps from R-1 to 0.
- owner holds its last value through GAP and IDLE.

## Timing
- Reset values: state IDLE, ptr 0, grant 0, busy 0, owner 0, remaining 0, expire 0.
- Reset is asynchronous; all outputs go to these values immediately. Reset mid-slot drops grant without an expire pulse.
- grant, busy and remaining are registered.
  - A request seen in IDLE at edge k gives grant high from edge k until the edge at which the slot end is sampled.
  - The end condition sampled at edge j drops grant after edge j.
- A full slot of Q cycles keeps grant high for exactly Q cycles. remaining shows Q, Q-1, ..., 1 during those cycles.
- expire is high in the first GAP cycle.
- Minimum request-to-grant latency from IDLE is 1 cycle. Back-to-back owners: the last grant cycle is followed by 2 grant-free cycles, then the next grant.
- Simultaneous rel[owner] and remaining == 1: the slot ends and expire stays 0.
- When the owner's req drops in GRANT, the release takes effect at that same edge.

## Test plan
- Reset, then req=4'b0001, quantum=3 -> grant=0001 for exactly 3 cycles with remaining 3,2,1; expire pulses once; owner=0; after GAP and IDLE the same requester is regranted.
- req=4'b1111 held, quantum=2 -> grants in order 0001, 0010, 0100, 1000, 0001; each lasts 2 cycles with 2 idle cycles between.
- Owner 1 with quantum=5 asserts rel[1] in its 2nd grant cycle -> grant drops after 2 cycles; expire=0; next grant goes to requester 2 if requesting.
- quantum=0 -> 1-cycle slot, remaining=1, expire pulses. Change quantum from 4 to 1 during a slot -> the slot still lasts 4 cycles.
- Owner 3 drops req mid-slot while req[0] is high -> GAP, then grant=0001 (ptr wraps to 0); rel bits of non-owners are ignored throughout.
- Assert reset in the 2nd cycle of a 6-cycle slot -> grant=0, busy=0, remaining=0, expire=0 immediately. After release with req=0010, grant goes to requester 1 (ptr was reset to 0).

Source files
------------

// File: rtl/timeslot_arbiter_if.sv
// Bundle of request, grant and monitoring signals shared between the requesting agents
// and the time-slot arbiter.
interface timeslot_arbiter_if #(
   parameter int R = 4,
   parameter int N = 8
);
   localparam int W = (R > 1) ? $clog2(R) : 1;

   logic [R-1:0] req;
   logic [R-1:0] rel;
   logic [N-1:0] quantum;
   logic [R-1:0] grant;
   logic         busy;
   logic [W-1:0] owner;
   logic [N-1:0] remaining;
   logic         expire;

   modport master (
      output req, rel, quantum,
      input  grant, busy, owner, remaining, expire
   );

   modport slave (
      input  req, rel, quantum,
      output grant, busy, owner, remaining, expire
   );
endinterface

// File: rtl/timeslot_arbiter.sv
// Round-robin time-slot arbiter: one requester at a time owns the resource for up to
// quantum cycles, followed by a dead GAP cycle and an IDLE arbitration cycle.
module timeslot_arbiter #(
   parameter int R = 4,
   parameter int N = 8
) (
   input  logic                clock,
   input  logic                reset,
   timeslot_arbiter_if.slave   bus
);
   localparam int W = (R > 1) ? $clog2(R) : 1;
   localparam logic [W:0]   R_EXT = (W+1)'(R);
   localparam logic [W-1:0] LAST  = W'(R - 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t       state_reg;
   logic [W-1:0] ptr_reg;
   logic [W-1:0] owner_reg;
   logic [R-1:0] grant_reg;
   logic         busy_reg;
   logic         expire_reg;
   logic [N-1:0] remaining_reg;

   logic [W-1:0] sel;
   logic         found;
   logic [W:0]   cand;
   logic [R-1:0] owner_dec;
   logic [R-1:0] sel_dec;
   logic         rel_own;
   logic         req_own;
   logic         timeout;
   logic         slot_end;

   // Decoders: only the owner's rel/req bits matter; sel_dec is the grant to load.
   generate
      for (genvar gi = 0; gi < R; gi++) begin : g_dec
         assign owner_dec[gi] = (owner_reg == W'(gi));
         assign sel_dec[gi]   = (sel == W'(gi));
      end
   endgenerate

   assign rel_own  = |(bus.rel & owner_dec);
   assign req_own  = |(bus.req & owner_dec);
   assign timeout  = (remaining_reg == N'(1));
   assign slot_end = rel_own || !req_own || timeout;

   // First requester at or after ptr, wrapping modulo R.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < R; i++) begin
         cand = {1'b0, ptr_reg} + (W+1)'(i);
         if (cand >= R_EXT)
            cand = cand - R_EXT;
         if (!found && bus.req[cand[W-1:0]]) begin
            found = 1'b1;
            sel   = cand[W-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         owner_reg     <= '0;
         grant_reg     <= '0;
         busy_reg      <= 1'b0;
         expire_reg    <= 1'b0;
         remaining_reg <= '0;
      end else begin
         expire_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (found) begin
                  state_reg     <= GRANT;
                  owner_reg     <= sel;
                  grant_reg     <= sel_dec;
                  busy_reg      <= 1'b1;
                  remaining_reg <= (bus.quantum == '0) ? N'(1) : bus.quantum;
               end
            end
            GRANT: begin
               if (slot_end) begin
                  state_reg     <= GAP;
                  grant_reg     <= '0;
                  busy_reg      <= 1'b0;
                  remaining_reg <= '0;
                  ptr_reg       <= (owner_reg == LAST) ? '0 : owner_reg + W'(1);
                  // Only a pure timeout counts as an expiry.
                  expire_reg    <= timeout && !rel_own && req_own;
               end else begin
                  remaining_reg <= remaining_reg - N'(1);
               end
            end
            GAP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant     = grant_reg;
   assign bus.busy      = busy_reg;
   assign bus.owner     = owner_reg;
   assign bus.remaining = remaining_reg;
   assign bus.expire    = expire_reg;
endmodule

// File: tb/tb_timeslot_arbiter.sv
// Directed bench for timeslot_arbiter: each scenario task drives inputs and checks the
// cycle-by-cycle outputs against hand-derived values.
module tb_timeslot_arbiter;
   logic clock;
   logic reset;
   int   tests;
   int   fails;

   timeslot_arbiter_if #(.R(4), .N(8)) bus ();

   timeslot_arbiter #(.R(4), .N(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = '0;
      bus.rel = '0;
      bus.quantum = 8'd0;
      #2;
      tests++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 ||
          bus.remaining !== 8'd0 || bus.expire !== 1'b0) begin
         fails++;
         $display("FAIL reset_values grant=%b busy=%b owner=%0d rem=%0d expire=%b expected 0000/0/0/0/0",
                  bus.grant, bus.busy, bus.owner, bus.remaining, bus.expire);
      end
      tick();
      reset = 1'b0;
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_req grant=%b busy=%b expected 0000/0", bus.grant, bus.busy);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      bus.req = 4'b0001;
      bus.quantum = 8'd3;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if (bus.grant !== 4'b0001 || bus.busy !== 1'b1 || bus.owner !== 2'd0 ||
             bus.remaining !== 8'(3 - c) || bus.expire !== 1'b0) begin
            fails++;
            $display("FAIL single_grant%0d grant=%b busy=%b owner=%0d rem=%0d expire=%b expected 0001/1/0/%0d/0",
                     c, bus.grant, bus.busy, bus.owner, bus.remaining, bus.expire, 3 - c);
         end
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.remaining !== 8'd0 || bus.expire !== 1'b1) begin
         fails++;
         $display("FAIL single_gap grant=%b busy=%b rem=%0d expire=%b expected 0000/0/0/1",
                  bus.grant, bus.busy, bus.remaining, bus.expire);
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b0 || bus.owner !== 2'd0) begin
         fails++;
         $display("FAIL single_idle grant=%b expire=%b owner=%0d expected 0000/0/0",
                  bus.grant, bus.expire, bus.owner);
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0001 || bus.remaining !== 8'd3) begin
         fails++;
         $display("FAIL single_regrant grant=%b rem=%0d expected 0001/3", bus.grant, bus.remaining);
      end
      bus.req = 4'b0000;
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b0) begin
         fails++;
         $display("FAIL single_req_drop grant=%b expire=%b expected 0000/0", bus.grant, bus.expire);
      end
      tick();
      $display("[TB] test_single done");
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_g;
      logic [7:0] exp_r;
      logic       exp_e;
      apply_reset();
      bus.req = 4'b1111;
      bus.quantum = 8'd2;
      for (int c = 0; c < 18; c++) begin
         tick();
         exp_g = ((c % 4) < 2) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
         exp_r = ((c % 4) == 0) ? 8'd2 : (((c % 4) == 1) ? 8'd1 : 8'd0);
         exp_e = ((c % 4) == 2);
         tests++;
         if (bus.grant !== exp_g || bus.remaining !== exp_r || bus.expire !== exp_e) begin
            fails++;
            $display("FAIL rr_cycle%0d grant=%b rem=%0d expire=%b expected %b/%0d/%b",
                     c, bus.grant, bus.remaining, bus.expire, exp_g, exp_r, exp_e);
         end
      end
      bus.req = 4'b0000;
      tick();
      tick();
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_release();
      apply_reset();
      bus.req = 4'b0010;
      bus.quantum = 8'd5;
      tick();
      tests++;
      if (bus.grant !== 4'b0010 || bus.owner !== 2'd1 || bus.remaining !== 8'd5) begin
         fails++;
         $display("FAIL rel_first grant=%b owner=%0d rem=%0d expected 0010/1/5",
                  bus.grant, bus.owner, bus.remaining);
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0010 || bus.remaining !== 8'd4) begin
         fails++;
         $display("FAIL rel_second grant=%b rem=%0d expected 0010/4", bus.grant, bus.remaining);
      end
      bus.rel = 4'b0010;
      bus.req = 4'b0110;
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL rel_drop grant=%b expire=%b busy=%b expected 0000/0/0",
                  bus.grant, bus.expire, bus.busy);
      end
      bus.rel = 4'b0000;
      tick();
      tick();
      tests++;
      if (bus.grant !== 4'b0100 || bus.owner !== 2'd2 || bus.remaining !== 8'd5) begin
         fails++;
         $display("FAIL rel_next_owner grant=%b owner=%0d rem=%0d expected 0100/2/5",
                  bus.grant, bus.owner, bus.remaining);
      end
      bus.rel = 4'b1011;
      tick();
      tests++;
      if (bus.grant !== 4'b0100 || bus.remaining !== 8'd4) begin
         fails++;
         $display("FAIL rel_nonowner_ignored grant=%b rem=%0d expected 0100/4", bus.grant, bus.remaining);
      end
      bus.rel = 4'b0000;
      bus.req = 4'b0000;
      tick();
      tick();
      $display("[TB] test_release done");
   endtask

   task automatic test_quantum();
      apply_reset();
      bus.req = 4'b0001;
      bus.quantum = 8'd0;
      tick();
      tests++;
      if (bus.grant !== 4'b0001 || bus.remaining !== 8'd1) begin
         fails++;
         $display("FAIL q0_grant grant=%b rem=%0d expected 0001/1", bus.grant, bus.remaining);
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b1) begin
         fails++;
         $display("FAIL q0_expire grant=%b expire=%b expected 0000/1", bus.grant, bus.expire);
      end
      bus.quantum = 8'd4;
      tick();
      tick();
      tests++;
      if (bus.grant !== 4'b0001 || bus.remaining !== 8'd4) begin
         fails++;
         $display("FAIL q4_grant grant=%b rem=%0d expected 0001/4", bus.grant, bus.remaining);
      end
      bus.quantum = 8'd1;
      for (int c = 1; c < 4; c++) begin
         tick();
         tests++;
         if (bus.grant !== 4'b0001 || bus.remaining !== 8'(4 - c)) begin
            fails++;
            $display("FAIL q_change_cycle%0d grant=%b rem=%0d expected 0001/%0d",
                     c, bus.grant, bus.remaining, 4 - c);
         end
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b1) begin
         fails++;
         $display("FAIL q_change_expire grant=%b expire=%b expected 0000/1", bus.grant, bus.expire);
      end
      bus.req = 4'b0000;
      tick();
      $display("[TB] test_quantum done");
   endtask

   task automatic test_drop_wrap();
      apply_reset();
      bus.req = 4'b1000;
      bus.rel = 4'b0111;
      bus.quantum = 8'd5;
      tick();
      tests++;
      if (bus.grant !== 4'b1000 || bus.owner !== 2'd3) begin
         fails++;
         $display("FAIL wrap_owner3 grant=%b owner=%0d expected 1000/3", bus.grant, bus.owner);
      end
      bus.req = 4'b1001;
      tick();
      tests++;
      if (bus.grant !== 4'b1000 || bus.remaining !== 8'd4) begin
         fails++;
         $display("FAIL wrap_hold grant=%b rem=%0d expected 1000/4", bus.grant, bus.remaining);
      end
      bus.req = 4'b0001;
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.expire !== 1'b0 || bus.owner !== 2'd3) begin
         fails++;
         $display("FAIL wrap_drop grant=%b expire=%b owner=%0d expected 0000/0/3",
                  bus.grant, bus.expire, bus.owner);
      end
      bus.req = 4'b1011;
      bus.rel = 4'b0000;
      tick();
      tests++;
      if (bus.grant !== 4'b0000 || bus.owner !== 2'd3) begin
         fails++;
         $display("FAIL wrap_idle grant=%b owner=%0d expected 0000/3", bus.grant, bus.owner);
      end
      tick();
      tests++;
      if (bus.grant !== 4'b0001 || bus.owner !== 2'd0) begin
         fails++;
         $display("FAIL wrap_ptr grant=%b owner=%0d expected 0001/0", bus.grant, bus.owner);
      end
      bus.req = 4'b0000;
      tick();
      tick();
      $display("[TB] test_drop_wrap done");
   endtask

   task automatic test_reset_midslot();
      bus.req = 4'b0100;
      bus.quantum = 8'd6;
      tick();
      tick();
      tests++;
      if (bus.grant !== 4'b0100 || bus.remaining !== 8'd5) begin
         fails++;
         $display("FAIL midrst_pre grant=%b rem=%0d expected 0100/5", bus.grant, bus.remaining);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.remaining !== 8'd0 ||
          bus.expire !== 1'b0 || bus.owner !== 2'd0) begin
         fails++;
         $display("FAIL midrst_async grant=%b busy=%b rem=%0d expire=%b owner=%0d expected 0000/0/0/0/0",
                  bus.grant, bus.busy, bus.remaining, bus.expire, bus.owner);
      end
      bus.req = 4'b0010;
      #1;
      reset = 1'b0;
      tick();
      tests++;
      if (bus.grant !== 4'b0010 || bus.owner !== 2'd1 || bus.expire !== 1'b0 || bus.remaining !== 8'd6) begin
         fails++;
         $display("FAIL midrst_regrant grant=%b owner=%0d expire=%b rem=%0d expected 0010/1/0/6",
                  bus.grant, bus.owner, bus.expire, bus.remaining);
      end
      bus.req = 4'b0000;
      tick();
      tick();
      $display("[TB] test_reset_midslot done");
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_release();
      test_quantum();
      test_drop_wrap();
      test_reset_midslot();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
